// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg
//   Definitions shared by the AXI4-Lite slave and its memory responder:
//   - mem_resp_state_t : responder FSM states (IDLE, WAIT, RESP, HOLD)
//   - bytes_of()       : bytes per data word
//   - idx_width()      : width of a word index for a given depth
//   - OKAY / SLVERR    : AXI response codes
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } mem_resp_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_mem_ram.sv
// axi4_lite_mem_ram
//   Single-port synchronous RAM, registered read, write enable.
//   Contents are not reset.
// Ports:
//   clk   : clock
//   we    : write enable, writes wdata to mem[addr]
//   addr  : word index (shared by read and write)
//   wdata : write data
//   rdata : mem[addr] as of the previous clock edge (read-before-write)
module axi4_lite_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/axi4_lite_mem_responder.sv
// axi4_lite_mem_responder
//   Memory endpoint for the AXI4-Lite slave. Accepts one read or write
//   request in IDLE, waits LATENCY cycles, then pulses successful_access_o
//   for exactly one cycle (RESP) together with successful_read_o or
//   successful_write_o when the access decoded as in-range and aligned.
//   Held requests are absorbed in HOLD until both request lines drop.
//
// Handshake: a request is taken only in IDLE when we_i or read_request_i is
//   high (write wins when both are); addr_i/data_i are captured at that
//   edge. Completion is the one-cycle successful_access_o pulse; data_o is
//   valid during a successful read pulse and holds until the next one.
//
// Ports:
//   clk_i, arst_i        : clock, synchronous active-high reset
//   addr_i, data_i       : byte address and write data
//   we_i, read_request_i : request lines
//   data_o               : read data
//   successful_access_o  : completion pulse for any request
//   successful_read_o    : valid read completed (only with access)
//   successful_write_o   : valid write completed (only with access)
//   busy_o               : FSM not in IDLE
//
// Optional build macro AXI4_LITE_MEM_ERR_INJECT_EN adds err_inject_i
//   (forces the accepted access invalid) and err_count_o (saturating count
//   of invalid completions).
module axi4_lite_mem_responder
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  we_i,
  input  logic                  read_request_i,
`ifdef AXI4_LITE_MEM_ERR_INJECT_EN
  input  logic                  err_inject_i,
  output logic [15:0]           err_count_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  successful_access_o,
  output logic                  successful_read_o,
  output logic                  successful_write_o,
  output logic                  busy_o
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int OFFS  = $clog2(BYTES);
  localparam int IW    = idx_width(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_DEPTH) << OFFS;
  localparam logic [3:0] LAT = 4'(LATENCY);

  mem_resp_state_t state_q, state_d;
  logic [3:0]            cnt_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_op_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] ram_q;

  // Decode of the live address. Subtraction wraps in ADDR_WIDTH bits, so an
  // address below BASE_ADDR lands far above SPAN and is rejected.
  logic [ADDR_WIDTH-1:0] offset;
  logic                  addr_ok;
  logic [IW-1:0]         live_idx;
  logic                  req;
  logic                  accept;
  logic                  in_resp;
  logic [IW-1:0]         ram_addr;

  assign offset   = addr_i - BASE_ADDR;
  assign addr_ok  = (offset < SPAN) && (addr_i[OFFS-1:0] == '0);
  assign live_idx = offset[OFFS +: IW];
  assign req      = we_i | read_request_i;
  assign accept   = (state_q == IDLE) && req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = (LAT == 4'd0) ? RESP : WAIT;
      WAIT: if (cnt_q <= 4'd1) state_d = RESP;
      RESP: state_d = HOLD;
      HOLD: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= LAT;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (in_resp && valid_q && !wr_op_q) begin
        data_q <= ram_q;
      end
    end
  end

  // Captured request; no reset needed since it is only consumed after an
  // accept has loaded it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= live_idx;
      wdata_q <= data_i;
      wr_op_q <= we_i;
`ifdef AXI4_LITE_MEM_ERR_INJECT_EN
      valid_q <= addr_ok && !err_inject_i;
`else
      valid_q <= addr_ok;
`endif
    end
  end

`ifdef AXI4_LITE_MEM_ERR_INJECT_EN
  logic [15:0] err_count_q;
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      err_count_q <= '0;
    end else if (in_resp && !valid_q && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end
  assign err_count_o = err_count_q;
`endif

  // Reset gates the RESP cycle so a coinciding write is dropped and no
  // pulse escapes.
  assign in_resp = (state_q == RESP) && !arst_i;

  // In IDLE the RAM is addressed from the live request so its registered
  // output is already valid in RESP even with LATENCY of 0.
  assign ram_addr = (state_q == IDLE) ? live_idx : idx_q;

  axi4_lite_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .AW         (IW)
  ) u_ram (
    .clk   (clk_i),
    .we    (successful_write_o),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  assign successful_access_o = in_resp;
  assign successful_write_o  = in_resp && valid_q && wr_op_q;
  assign successful_read_o   = in_resp && valid_q && !wr_op_q;
  assign data_o              = successful_read_o ? ram_q : data_q;
  assign busy_o              = (state_q != IDLE);

endmodule
